alu_secuenciador: RTL and testbench
===================================

ALU_SECUENCIADOR -- requirements
Module: alu_secuenciador

Interface
REQ-001 SHALL have port i_Clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port i_Rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port i_Valido  input  1  command valid.
REQ-004 SHALL have port o_Listo  output  1  command ready; high only in state IDLE.
REQ-005 SHALL have port i_Opcode  input  3  ALU operation: 000 add, 001 sub, 010 shl, 011 shr, 100 not B, 101 and, 110 or, 111 xor.
REQ-006 SHALL have ports i_Dir_A, i_Dir_B, i_Dir_D  input  2 each  source A, source B and destination register indices.
REQ-007 SHALL have ports i_Usa_Inm  input  1 and i_Inmediato  input  8; when i_Usa_Inm=1, operand B is i_Inmediato instead of R[i_Dir_B].
REQ-008 SHALL have ports i_Escribe_Ext  input  1, i_Dir_Ext  input  2, i_Dato_Ext  input  8  external register load.
REQ-009 SHALL have port o_Control_ALU  output  4  {enable, opcode} to the ALU.
REQ-010 SHALL have port o_Operandos  output  16  {op B[15:8], op A[7:0]} to the ALU.
REQ-011 SHALL have ports i_Resultado  input  8 and i_Banderas  input  3  ALU result and flags {Z,N,C}.
REQ-012 SHALL have ports o_Dato  output  8, o_Banderas  output  3 and o_Hecho  output  1  last result, last flags, and a one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> LEER -> EJECUTAR -> ESCRIBIR -> IDLE, one cycle per state except IDLE.
REQ-014 SHALL accept a command on a rising edge with i_Valido=1 and o_Listo=1, latching opcode, D, A, B, immediate and i_Usa_Inm; IDLE -> LEER.
REQ-015 SHALL, on the LEER -> EJECUTAR edge, register op A=R[A] and op B=(i_Usa_Inm ? immediate : R[B]) into o_Operandos; both stay stable until the next accepted command.
REQ-016 SHALL drive o_Control_ALU={1,opcode} only in EJECUTAR; in every other state it is {0,opcode latched}, so the ALU holds its result.
REQ-017 SHALL, on the ESCRIBIR -> IDLE edge, write i_Resultado into R[D] and load o_Dato=i_Resultado and o_Banderas=i_Banderas.
REQ-018 SHALL assert o_Hecho for exactly the first IDLE cycle after ESCRIBIR; o_Dato and o_Banderas hold until the next completion.
REQ-019 SHALL accept a new command in the same cycle o_Hecho is high; latency is 4 cycles from accept to o_Hecho, and throughput is one command per 4 cycles.
REQ-020 SHALL apply i_Escribe_Ext only while in IDLE; it is ignored in LEER, EJECUTAR and ESCRIBIR.
REQ-021 SHALL, when an external write and a command accept share an edge, write the external data first, so LEER reads the new value.
REQ-022 SHALL allow D equal to A or B; the read in LEER precedes the write in ESCRIBIR, so the old value is used as the operand.
REQ-023 SHALL ignore i_Valido while o_Listo=0; no command is queued.

Reset
REQ-024 SHALL, on i_Rst_n=0, immediately force state IDLE, R0..R3=0, o_Operandos=0, o_Control_ALU=0, o_Dato=0, o_Banderas=0 and o_Hecho=0, with o_Listo=1.
REQ-025 SHALL, on reset mid-command, abort with no register write-back and no o_Hecho pulse.

Structure
REQ-026 SHALL place opcode encodings, FSM state encodings (2 bits) and widths (data 8, address 2, flags 3) in a shared package.
REQ-027 SHALL implement the register file as sub-module banco_registros: 4x8, two asynchronous read ports, one write port, asynchronous active-low reset.

Verification
REQ-028 SHALL cover: after reset, load R1=0x05 and R2=0x03, then add A=1 B=2 D=3 -> o_Hecho 4 cycles after accept, o_Dato=0x08, o_Banderas=000, R3=0x08.
REQ-029 SHALL cover: sub with R1=0x03, R2=0x03, D=0 -> o_Dato=0x00 and Z=1.
REQ-030 SHALL cover: immediate xor with R1=0xFF, Inm=0x0F, D=1 -> R1=0xF0; then a back-to-back command accepted in the o_Hecho cycle reads R1=0xF0.
REQ-031 SHALL cover: i_Escribe_Ext R2=0x77 asserted during EJECUTAR -> R2 unchanged; the same write asserted on the accept edge -> operand B=0x77.
REQ-032 SHALL cover: i_Rst_n pulsed low during EJECUTAR -> R[D] unchanged (0 after reset), no o_Hecho, and o_Listo=1 asynchronously.
REQ-033 SHALL cover: i_Valido held high continuously -> accepts occur exactly every 4 cycles, and o_Control_ALU[3] is high for exactly one cycle per command.

Source files
------------

// File: rtl/alu_secuenciador_pkg.sv
// alu_secuenciador_pkg: shared widths, opcode and FSM state encodings for the ALU sequencer.
package alu_secuenciador_pkg;
   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 2;
   localparam int FLAG_W   = 3;
   localparam int OP_W     = 3;
   localparam int NUM_REGS = 1 << ADDR_W;
   typedef enum logic [OP_W-1:0] {
      OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_NOT, OP_AND, OP_OR, OP_XOR
   } opcode_e;
   typedef enum logic [1:0] {IDLE, LEER, EJECUTAR, ESCRIBIR} estado_e;
endpackage

// File: rtl/alu_secuenciador_banco_registros.sv
// banco_registros: 4x8 register file, two asynchronous read ports, one write port.
module banco_registros
   import alu_secuenciador_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [ADDR_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o
);
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) regs_q <= '{default: '0};
      else if (we_i) regs_q[waddr_i] <= wdata_i;
   end
   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];
endmodule

// File: rtl/alu_secuenciador.sv
// alu_secuenciador: sequences read / execute / write-back of register commands around an external ALU.
module alu_secuenciador
   import alu_secuenciador_pkg::*;
(
   input  logic                i_Clk,
   input  logic                i_Rst_n,
   input  logic                i_Valido,
   output logic                o_Listo,
   input  logic [OP_W-1:0]     i_Opcode,
   input  logic [ADDR_W-1:0]   i_Dir_A,
   input  logic [ADDR_W-1:0]   i_Dir_B,
   input  logic [ADDR_W-1:0]   i_Dir_D,
   input  logic                i_Usa_Inm,
   input  logic [DATA_W-1:0]   i_Inmediato,
   input  logic                i_Escribe_Ext,
   input  logic [ADDR_W-1:0]   i_Dir_Ext,
   input  logic [DATA_W-1:0]   i_Dato_Ext,
   output logic [OP_W:0]       o_Control_ALU,
   output logic [2*DATA_W-1:0] o_Operandos,
   input  logic [DATA_W-1:0]   i_Resultado,
   input  logic [FLAG_W-1:0]   i_Banderas,
   output logic [DATA_W-1:0]   o_Dato,
   output logic [FLAG_W-1:0]   o_Banderas,
   output logic                o_Hecho
);
   estado_e             estado_q;
   logic [OP_W-1:0]     opcode_q;
   logic [ADDR_W-1:0]   dir_a_q, dir_b_q, dir_d_q;
   logic                usa_inm_q, en_q, listo_q, hecho_q;
   logic [DATA_W-1:0]   inm_q, dato_q, rd_a, rd_b, wdata;
   logic [2*DATA_W-1:0] operandos_q;
   logic [FLAG_W-1:0]   banderas_q;
   logic [ADDR_W-1:0]   waddr;
   logic                we, wb;
   // The single write port is shared: external loads only happen in IDLE, write-back only in ESCRIBIR.
   assign wb    = estado_q == ESCRIBIR;
   assign we    = wb || (estado_q == IDLE && i_Escribe_Ext);
   assign waddr = wb ? dir_d_q : i_Dir_Ext;
   assign wdata = wb ? i_Resultado : i_Dato_Ext;
   banco_registros u_banco (
      .clk_i     (i_Clk),
      .rst_n_i   (i_Rst_n),
      .we_i      (we),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .raddr_a_i (dir_a_q),
      .rdata_a_o (rd_a),
      .raddr_b_i (dir_b_q),
      .rdata_b_o (rd_b)
   );
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         estado_q    <= IDLE;
         opcode_q    <= '0;
         dir_a_q     <= '0;
         dir_b_q     <= '0;
         dir_d_q     <= '0;
         usa_inm_q   <= 1'b0;
         inm_q       <= '0;
         en_q        <= 1'b0;
         listo_q     <= 1'b1;
         hecho_q     <= 1'b0;
         operandos_q <= '0;
         dato_q      <= '0;
         banderas_q  <= '0;
      end else begin
         hecho_q <= estado_q == ESCRIBIR;
         case (estado_q)
            IDLE: if (i_Valido) begin
               opcode_q  <= i_Opcode;
               dir_a_q   <= i_Dir_A;
               dir_b_q   <= i_Dir_B;
               dir_d_q   <= i_Dir_D;
               usa_inm_q <= i_Usa_Inm;
               inm_q     <= i_Inmediato;
               listo_q   <= 1'b0;
               estado_q  <= LEER;
            end
            LEER: begin
               operandos_q <= {usa_inm_q ? inm_q : rd_b, rd_a};
               en_q        <= 1'b1;
               estado_q    <= EJECUTAR;
            end
            EJECUTAR: begin
               en_q     <= 1'b0;
               estado_q <= ESCRIBIR;
            end
            default: begin
               dato_q     <= i_Resultado;
               banderas_q <= i_Banderas;
               listo_q    <= 1'b1;
               estado_q   <= IDLE;
            end
         endcase
      end
   end
   assign o_Listo       = listo_q;
   assign o_Control_ALU = {en_q, opcode_q};
   assign o_Operandos   = operandos_q;
   assign o_Dato        = dato_q;
   assign o_Banderas    = banderas_q;
   assign o_Hecho       = hecho_q;
endmodule

// File: tb/tb_alu_secuenciador.sv
// tb_alu_secuenciador: directed + randomized checks of the sequencer against a register-array model.
module tb_alu_secuenciador;
   import alu_secuenciador_pkg::*;
   logic        i_Clk = 1'b0, i_Rst_n = 1'b0, i_Valido = 1'b0, i_Usa_Inm = 1'b0, i_Escribe_Ext = 1'b0;
   logic [2:0]  i_Opcode = '0, i_Banderas = '0;
   logic [1:0]  i_Dir_A = '0, i_Dir_B = '0, i_Dir_D = '0, i_Dir_Ext = '0;
   logic [7:0]  i_Inmediato = '0, i_Dato_Ext = '0, i_Resultado = '0;
   logic        o_Listo, o_Hecho;
   logic [3:0]  o_Control_ALU;
   logic [15:0] o_Operandos;
   logic [7:0]  o_Dato;
   logic [2:0]  o_Banderas;
   int          tests = 0, failed = 0, cmd_n = 0;
   logic [7:0]  R [4];

   alu_secuenciador dut (
      .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Valido(i_Valido), .o_Listo(o_Listo),
      .i_Opcode(i_Opcode), .i_Dir_A(i_Dir_A), .i_Dir_B(i_Dir_B), .i_Dir_D(i_Dir_D),
      .i_Usa_Inm(i_Usa_Inm), .i_Inmediato(i_Inmediato), .i_Escribe_Ext(i_Escribe_Ext),
      .i_Dir_Ext(i_Dir_Ext), .i_Dato_Ext(i_Dato_Ext), .o_Control_ALU(o_Control_ALU),
      .o_Operandos(o_Operandos), .i_Resultado(i_Resultado), .i_Banderas(i_Banderas),
      .o_Dato(o_Dato), .o_Banderas(o_Banderas), .o_Hecho(o_Hecho)
   );

   always #5 i_Clk = ~i_Clk;

   // Returns {Z,N,C,result}; C is carry for add, borrow for sub, shifted-out bit for shifts.
   function automatic logic [10:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] w;
      case (op)
         OP_ADD:  w = {1'b0, a} + {1'b0, b};
         OP_SUB:  w = {1'b0, a} - {1'b0, b};
         OP_SHL:  w = {a, 1'b0};
         OP_SHR:  w = {a[0], 1'b0, a[7:1]};
         OP_NOT:  w = {1'b0, ~b};
         OP_AND:  w = {1'b0, a & b};
         OP_OR:   w = {1'b0, a | b};
         default: w = {1'b0, a ^ b};
      endcase
      return {w[7:0] == 8'h00, w[7], w[8], w[7:0]};
   endfunction

   // External ALU: latches a result only while enabled, holds it otherwise.
   always @(posedge i_Clk)
      if (o_Control_ALU[3]) {i_Banderas, i_Resultado} <= alu_ref(o_Control_ALU[2:0], o_Operandos[7:0], o_Operandos[15:8]);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL cmd%0d %s: got %0h expected %0h", cmd_n, tag, obs, exp);
      end
   endtask

   task automatic ext_load(input logic [1:0] dir, input logic [7:0] dato);
      i_Escribe_Ext = 1'b1; i_Dir_Ext = dir; i_Dato_Ext = dato;
      R[dir] = dato;
      @(negedge i_Clk);
      i_Escribe_Ext = 1'b0;
      chk("hecho_idle", {15'b0, o_Hecho}, 16'h0);
   endtask

   // Starts on a negedge with the DUT idle; ends on the negedge of the o_Hecho cycle.
   // ext_when: 0 none, 1 external write on the accept edge, 2 external write during EJECUTAR.
   task automatic run_cmd(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                          input logic usa, input logic [7:0] inm, input int ext_when,
                          input logic [1:0] ext_dir, input logic [7:0] ext_dato);
      logic [7:0]  ea, eb;
      logic [10:0] r;
      cmd_n++;
      chk("listo_accept", {15'b0, o_Listo}, 16'h1);
      i_Valido = 1'b1; i_Opcode = op; i_Dir_A = a; i_Dir_B = b; i_Dir_D = d; i_Usa_Inm = usa; i_Inmediato = inm;
      if (ext_when == 1) begin
         i_Escribe_Ext = 1'b1; i_Dir_Ext = ext_dir; i_Dato_Ext = ext_dato;
         R[ext_dir] = ext_dato;
      end
      ea = R[a];
      eb = usa ? inm : R[b];
      r = alu_ref(op, ea, eb);
      @(negedge i_Clk);
      i_Valido = 1'b0; i_Escribe_Ext = 1'b0;
      chk("listo_leer", {15'b0, o_Listo}, 16'h0);
      chk("ctrl_leer", {12'b0, o_Control_ALU}, {12'b0, 1'b0, op});
      chk("hecho_leer", {15'b0, o_Hecho}, 16'h0);
      @(negedge i_Clk);
      chk("operandos", o_Operandos, {eb, ea});
      chk("ctrl_ejec", {12'b0, o_Control_ALU}, {12'b0, 1'b1, op});
      if (ext_when == 2) begin
         i_Escribe_Ext = 1'b1; i_Dir_Ext = ext_dir; i_Dato_Ext = ext_dato;
      end
      @(negedge i_Clk);
      i_Escribe_Ext = 1'b0;
      chk("ctrl_escr", {12'b0, o_Control_ALU}, {12'b0, 1'b0, op});
      chk("hecho_escr", {15'b0, o_Hecho}, 16'h0);
      @(negedge i_Clk);
      chk("hecho", {15'b0, o_Hecho}, 16'h1);
      chk("listo_fin", {15'b0, o_Listo}, 16'h1);
      chk("dato", {8'b0, o_Dato}, {8'b0, r[7:0]});
      chk("banderas", {13'b0, o_Banderas}, {13'b0, r[10:8]});
      R[d] = r[7:0];
   endtask

   task automatic read_reg(input logic [1:0] r);
      run_cmd(OP_AND, r, r, r, 1'b0, 8'h00, 0, 2'd0, 8'h00);
   endtask

   initial begin
      R = '{default: 8'h00};
      repeat (2) @(negedge i_Clk);
      chk("rst_listo", {15'b0, o_Listo}, 16'h1);
      chk("rst_ctrl", {12'b0, o_Control_ALU}, 16'h0);
      chk("rst_operandos", o_Operandos, 16'h0);
      chk("rst_dato", {5'b0, o_Banderas, o_Dato}, 16'h0);
      chk("rst_hecho", {15'b0, o_Hecho}, 16'h0);
      i_Rst_n = 1'b1;
      @(negedge i_Clk);
      // Basic add: R3 = R1 + R2
      ext_load(2'd1, 8'h05);
      ext_load(2'd2, 8'h03);
      run_cmd(OP_ADD, 2'd1, 2'd2, 2'd3, 1'b0, 8'h00, 0, 2'd0, 8'h00);
      chk("add_dato", {8'b0, o_Dato}, 16'h0008);
      chk("add_banderas", {13'b0, o_Banderas}, 16'h0);
      read_reg(2'd3);
      chk("r3_val", {8'b0, o_Dato}, 16'h0008);
      @(negedge i_Clk);
      // Subtract to zero sets Z
      ext_load(2'd1, 8'h03);
      ext_load(2'd2, 8'h03);
      run_cmd(OP_SUB, 2'd1, 2'd2, 2'd0, 1'b0, 8'h00, 0, 2'd0, 8'h00);
      chk("sub_dato", {8'b0, o_Dato}, 16'h0000);
      chk("sub_z", {13'b0, o_Banderas}, 16'h0004);
      @(negedge i_Clk);
      // Immediate xor then back-to-back read of the result
      ext_load(2'd1, 8'hFF);
      run_cmd(OP_XOR, 2'd1, 2'd0, 2'd1, 1'b1, 8'h0F, 0, 2'd0, 8'h00);
      chk("xor_dato", {8'b0, o_Dato}, 16'h00F0);
      run_cmd(OP_OR, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00, 0, 2'd0, 8'h00);
      chk("b2b_opa", {8'b0, o_Operandos[7:0]}, 16'h00F0);
      // External write ignored during EJECUTAR, honoured on the accept edge
      ext_load(2'd2, 8'h11);
      run_cmd(OP_ADD, 2'd0, 2'd1, 2'd3, 1'b0, 8'h00, 2, 2'd2, 8'h77);
      read_reg(2'd2);
      chk("ext_ignored", {8'b0, o_Dato}, 16'h0011);
      run_cmd(OP_NOT, 2'd0, 2'd2, 2'd3, 1'b0, 8'h00, 1, 2'd2, 8'h77);
      chk("ext_accept_opb", {8'b0, o_Operandos[15:8]}, 16'h0077);
      @(negedge i_Clk);
      // Reset during EJECUTAR aborts the command
      ext_load(2'd3, 8'h5A);
      cmd_n++;
      i_Valido = 1'b1; i_Opcode = OP_ADD; i_Dir_A = 2'd1; i_Dir_B = 2'd2; i_Dir_D = 2'd3; i_Usa_Inm = 1'b0;
      @(negedge i_Clk);
      i_Valido = 1'b0;
      @(negedge i_Clk);
      chk("abort_ejec", {15'b0, o_Control_ALU[3]}, 16'h1);
      #2 i_Rst_n = 1'b0;
      #1;
      chk("abort_listo", {15'b0, o_Listo}, 16'h1);
      chk("abort_ctrl", {12'b0, o_Control_ALU}, 16'h0);
      chk("abort_operandos", o_Operandos, 16'h0);
      R = '{default: 8'h00};
      @(negedge i_Clk);
      i_Rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge i_Clk);
         chk("abort_no_hecho", {15'b0, o_Hecho}, 16'h0);
      end
      read_reg(2'd3);
      chk("abort_r3", {8'b0, o_Dato}, 16'h0000);
      @(negedge i_Clk);
      // Valid held high: accept every 4 cycles, one enable cycle each
      ext_load(2'd0, 8'h3C);
      cmd_n++;
      i_Valido = 1'b1; i_Opcode = OP_AND; i_Dir_A = 2'd0; i_Dir_B = 2'd0; i_Dir_D = 2'd0; i_Usa_Inm = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("cont_listo", {15'b0, o_Listo}, {15'b0, k % 4 == 0});
         chk("cont_en", {15'b0, o_Control_ALU[3]}, {15'b0, k % 4 == 2});
         @(negedge i_Clk);
      end
      i_Valido = 1'b0;
      chk("cont_dato", {8'b0, o_Dato}, 16'h003C);
      @(negedge i_Clk);
      // Randomized commands against the register model
      for (int k = 0; k < 4; k++) ext_load(k[1:0], 8'($urandom));
      for (int k = 0; k < 12; k++)
         run_cmd(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                 8'($urandom), int'($urandom_range(0, 2)), 2'($urandom), 8'($urandom));
      for (int k = 0; k < 4; k++) read_reg(k[1:0]);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
